// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator. All channels share one N-bit timebase
// with a programmable prescaler. Mode, period and duty are loaded into staging
// registers and move to the active set only at a period boundary, or at once
// while the block is disabled.
//
// Optional feature macro: PWM_POLARITY_EN adds a staged per-channel output
// polarity input.
//
// Ports:
//   clk, rst_n    rising-edge clock; asynchronous active-low reset
//   enable        1 = timebase runs; 0 = timebase held at 0, outputs low
//   mode          0 = edge-aligned, 1 = center-aligned (staged)
//   prescale      timebase advances every prescale+1 clocks (used live)
//   period        top count value (staged)
//   duty          channel i duty in duty[i*N +: N] (staged)
//   polarity      per-channel output inversion (staged; PWM_POLARITY_EN only)
//   load          one-cycle strobe that captures the staged values
//   pwm_out       registered PWM outputs
//   period_tick   one-clock pulse aligned with the first output of each period
//   load_pending  staged values waiting for a boundary

module pwm_multi_lane #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable_i,
  input  logic         load_i,
  input  logic         apply_i,
  input  logic [N-1:0] duty_i,
  input  logic         pol_i,
  input  logic [N-1:0] cnt_i,
  output logic         pwm_o
);
  logic [N-1:0] stg_duty_q, act_duty_q;
  logic         stg_pol_q, act_pol_q;
  logic         pwm_d, pwm_q;

  // The compare uses the pre-update count, so the output lags cnt by one clock.
  assign pwm_d = enable_i & ((cnt_i < act_duty_q) ^ act_pol_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_duty_q <= '0;
      act_duty_q <= '0;
      stg_pol_q  <= 1'b0;
      act_pol_q  <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      if (load_i) begin
        stg_duty_q <= duty_i;
        stg_pol_q  <= pol_i;
      end
      // A load that lands on the applying edge bypasses staging.
      if (apply_i) begin
        act_duty_q <= load_i ? duty_i : stg_duty_q;
        act_pol_q  <= load_i ? pol_i  : stg_pol_q;
      end
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
endmodule

module pwm_multi #(
  parameter int N          = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [N-1:0]          period,
  input  logic [CHANNELS*N-1:0] duty,
`ifdef PWM_POLARITY_EN
  input  logic [CHANNELS-1:0]   polarity,
`endif
  input  logic                  load,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_tick,
  output logic                  load_pending
);
  logic [PRESCALE_W-1:0] presc_d, presc_q;
  logic [N-1:0]          cnt_d, cnt_q;
  logic                  dir_d, dir_q;
  logic                  stg_mode_q, act_mode_q;
  logic [N-1:0]          stg_top_q, act_top_q;
  logic                  pending_d, pending_q;
  logic [1:0]            vld_pipe_q;
  logic                  tick, boundary, apply;
  logic [CHANNELS-1:0]   pol;

`ifdef PWM_POLARITY_EN
  assign pol = polarity;
`else
  assign pol = '0;
`endif

  assign tick     = enable && (presc_q == prescale);
  assign boundary = tick && ((act_top_q == '0) ||
                             (!act_mode_q && (cnt_q == act_top_q)) ||
                             (act_mode_q && dir_q && (cnt_q == N'(1))));
  // While disabled there is no period to protect, so staged values go live
  // on the next clock.
  assign apply    = (boundary || !enable) && (pending_q || load);

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    // '>=' also covers prescale being lowered below the running count:
    // wrap to 0 without a tick.
    if (!enable)                presc_d = '0;
    else if (presc_q >= prescale) presc_d = '0;
    else                        presc_d = presc_q + PRESCALE_W'(1);

    if (!enable || boundary) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (!act_mode_q) begin
        cnt_d = cnt_q + N'(1);
      end else if (!dir_q) begin
        cnt_d = cnt_q + N'(1);
        // Turn around on reaching the top so the top count occurs once.
        if (cnt_q + N'(1) == act_top_q) dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q - N'(1);
      end
    end
  end

  assign pending_d = apply ? 1'b0 : (load ? 1'b1 : pending_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      stg_mode_q <= 1'b0;
      act_mode_q <= 1'b0;
      stg_top_q  <= '0;
      act_top_q  <= '1;
      pending_q  <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      if (load) begin
        stg_mode_q <= mode;
        stg_top_q  <= period;
      end
      if (apply) begin
        act_mode_q <= load ? mode   : stg_mode_q;
        act_top_q  <= load ? period : stg_top_q;
      end
      // Boundary is delayed two clocks so period_tick lines up with the
      // registered output of cnt=0 in the new period.
      vld_pipe_q <= {vld_pipe_q[0] & enable, boundary};
    end
  end

  assign period_tick  = vld_pipe_q[1];
  assign load_pending = pending_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pwm_multi_lane #(.N(N)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (enable),
      .load_i   (load),
      .apply_i  (apply),
      .duty_i   (duty[i*N +: N]),
      .pol_i    (pol[i]),
      .cnt_i    (cnt_q),
      .pwm_o    (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  prescale = '0;
  logic [7:0]  period = '0;
  logic [31:0] duty = '0;
  logic        load = 1'b0;
  logic [3:0]  pwm_out;
  logic        period_tick;
  logic        load_pending;
`ifdef PWM_POLARITY_EN
  logic [3:0]  polarity = '0;
`endif
  int checks = 0;
  int errors = 0;

  pwm_multi #(.N(8), .CHANNELS(4), .PRESCALE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode         (mode),
    .prescale     (prescale),
    .period       (period),
    .duty         (duty),
`ifdef PWM_POLARITY_EN
    .polarity     (polarity),
`endif
    .load         (load),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Disable, then load a configuration (applied on that edge since disabled).
  task automatic setup(input logic m, input logic [7:0] ps, input logic [7:0] per,
                       input logic [7:0] d0, d1, d2, d3);
    enable   = 1'b0;
    step();
    mode     = m;
    prescale = ps;
    period   = per;
    duty     = {d3, d2, d1, d0};
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // Center-mode count sequence for period 4.
  function automatic int cseq(int j);
    case (j)
      0: return 0; 1: return 1; 2: return 2; 3: return 3;
      4: return 4; 5: return 3; 6: return 2; default: return 1;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL reset_pwm got %b exp 0000", pwm_out); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", period_tick); end
    checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", load_pending); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_edge();
    logic [3:0] e;
    setup(1'b0, 8'd0, 8'd9, 8'd3, 8'd0, 8'd10, 8'd5);
    checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL edge_pending_dis got %b exp 0", load_pending); end
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      e = {((k % 10) < 5), 1'b1, 1'b0, ((k % 10) < 3)};
      checks++; if (pwm_out !== e) begin errors++; $display("FAIL edge_pwm k=%0d got %b exp %b", k, pwm_out, e); end
      checks++; if (period_tick !== (k % 10 == 0 && k > 0)) begin errors++; $display("FAIL edge_tick k=%0d got %b exp %b", k, period_tick, (k % 10 == 0 && k > 0)); end
    end
  endtask

  task automatic test_center();
    logic [3:0] e;
    int c;
    int high0 = 0;
    setup(1'b1, 8'd1, 8'd4, 8'd2, 8'd0, 8'd5, 8'd4);
    enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      c = cseq((k / 2) % 8);
      e = {(c < 4), 1'b1, 1'b0, (c < 2)};
      if (k >= 16 && k < 32 && pwm_out[0]) high0++;
      checks++; if (pwm_out !== e) begin errors++; $display("FAIL center_pwm k=%0d got %b exp %b", k, pwm_out, e); end
      checks++; if (period_tick !== (k % 16 == 0 && k > 0)) begin errors++; $display("FAIL center_tick k=%0d got %b exp %b", k, period_tick, (k % 16 == 0 && k > 0)); end
    end
    checks++; if (high0 != 6) begin errors++; $display("FAIL center_high_time got %0d exp 6", high0); end
  endtask

  task automatic test_extremes();
    logic [3:0] e;
    setup(1'b0, 8'd0, 8'd5, 8'd0, 8'd6, 8'd255, 8'd3);
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      e = {((k % 6) < 3), 1'b1, 1'b1, 1'b0};
      checks++; if (pwm_out !== e) begin errors++; $display("FAIL extreme_pwm k=%0d got %b exp %b", k, pwm_out, e); end
      checks++; if (period_tick !== (k % 6 == 0 && k > 0)) begin errors++; $display("FAIL extreme_tick k=%0d got %b exp %b", k, period_tick, (k % 6 == 0 && k > 0)); end
    end
  endtask

  task automatic test_reload();
    int d;
    setup(1'b0, 8'd0, 8'd9, 8'd3, 8'd0, 8'd0, 8'd0);
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      d = (k < 10) ? 3 : 7;
      checks++; if (pwm_out !== {3'b0, ((k % 10) < d)}) begin errors++; $display("FAIL reload_pwm k=%0d got %b exp %b", k, pwm_out, {3'b0, ((k % 10) < d)}); end
      checks++; if (load_pending !== (k >= 4 && k < 9)) begin errors++; $display("FAIL reload_pending k=%0d got %b exp %b", k, load_pending, (k >= 4 && k < 9)); end
      checks++; if (period_tick !== (k % 10 == 0 && k > 0)) begin errors++; $display("FAIL reload_tick k=%0d got %b exp %b", k, period_tick, (k % 10 == 0 && k > 0)); end
      if (k == 3) begin duty = {24'd0, 8'd7}; load = 1'b1; end
      if (k == 4) load = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int d;
    setup(1'b0, 8'd0, 8'd9, 8'd3, 8'd0, 8'd0, 8'd0);
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      d = (k < 10) ? 3 : (k < 20) ? 6 : 8;
      checks++; if (pwm_out !== {3'b0, ((k % 10) < d)}) begin errors++; $display("FAIL b2b_pwm k=%0d got %b exp %b", k, pwm_out, {3'b0, ((k % 10) < d)}); end
      checks++; if (load_pending !== (k >= 12 && k <= 18)) begin errors++; $display("FAIL b2b_pending k=%0d got %b exp %b", k, load_pending, (k >= 12 && k <= 18)); end
      if (k == 8)  begin duty = {24'd0, 8'd6}; load = 1'b1; end
      if (k == 11) begin duty = {24'd0, 8'd2}; load = 1'b1; end
      if (k == 14) begin duty = {24'd0, 8'd8}; load = 1'b1; end
      if (k == 9 || k == 12 || k == 15) load = 1'b0;
    end
  endtask

  task automatic test_enable();
    setup(1'b0, 8'd0, 8'd9, 8'd3, 8'd0, 8'd0, 8'd0);
    enable = 1'b1;
    repeat (11) step();   // cnt now 1 and output high (cnt 0 just compared)
    enable = 1'b0;
    step();
    checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL dis_pwm got %b exp 0000", pwm_out); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL dis_tick got %b exp 0", period_tick); end
    duty = {24'd0, 8'd5};
    load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL dis_load_pending got %b exp 0", load_pending); end
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (pwm_out !== {3'b0, ((k % 10) < 5)}) begin errors++; $display("FAIL reen_pwm k=%0d got %b exp %b", k, pwm_out, {3'b0, ((k % 10) < 5)}); end
      checks++; if (period_tick !== (k == 10)) begin errors++; $display("FAIL reen_tick k=%0d got %b exp %b", k, period_tick, (k == 10)); end
    end
  endtask

  task automatic test_async_reset();
    setup(1'b0, 8'd0, 8'd9, 8'd3, 8'd0, 8'd0, 8'd0);
    enable = 1'b1;
    step();
    duty = {24'd0, 8'd5};
    load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (pwm_out[0] !== 1'b1 || load_pending !== 1'b1) begin errors++; $display("FAIL pre_rst got pwm=%b pend=%b exp 1 1", pwm_out[0], load_pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL rst_pwm got %b exp 0000", pwm_out); end
    checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", load_pending); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b exp 0", period_tick); end
    @(negedge clk);
    rst_n = 1'b1;
    // Active duty resets to 0: outputs stay low even while enabled.
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL post_rst_pwm k=%0d got %b exp 0000", k, pwm_out); end
    end
    // Active top resets to 255, so a load while running stays pending.
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    checks++; if (load_pending !== 1'b1) begin errors++; $display("FAIL post_rst_pending got %b exp 1", load_pending); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_extremes();
    test_reload();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
